// File: rtl/rr_bus_arbiter4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_bus_arbiter4_pkg: shared types/constants for the 4-way arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package rr_bus_arbiter4_pkg;
    localparam int NREQ  = 4;
    localparam int SELW  = 2;
    localparam int MUX_W = 20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;
endpackage
`default_nettype wire

// File: rtl/rr_bus_arbiter4_mux4to1.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux4to1: 20-bit 4:1 datapath multiplexer                            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mux4to1
    import rr_bus_arbiter4_pkg::*;
(
    input  logic [MUX_W-1:0] d0_i,
    input  logic [MUX_W-1:0] d1_i,
    input  logic [MUX_W-1:0] d2_i,
    input  logic [MUX_W-1:0] d3_i,
    input  logic [SELW-1:0]  sel_i,
    output logic [MUX_W-1:0] y_o
);
    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/rr_bus_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_bus_arbiter4: round-robin, packet-locked 4-way bus arbiter with  |
// | a one-deep valid/ready output register.          Rev 1.0            |
// +--------------------------------------------------------------------+
module rr_bus_arbiter4
    import rr_bus_arbiter4_pkg::*;
#(
    parameter int unsigned DW        = 20,
    parameter int unsigned START_PTR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [NREQ-1:0] req_last_i,
    input  logic [DW-1:0]   req_data0_i,
    input  logic [DW-1:0]   req_data1_i,
    input  logic [DW-1:0]   req_data2_i,
    input  logic [DW-1:0]   req_data3_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic            out_valid_o,
    output logic [DW-1:0]   out_data_o,
    output logic [SELW-1:0] out_src_o,
    output logic            out_last_o,
    input  logic            out_ready_i,
    output logic            busy_o,
    output logic [SELW-1:0] gnt_o
);
    localparam logic [SELW-1:0] RST_PTR = SELW'(START_PTR);

    arb_state_e      state_q;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] gnt_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [SELW-1:0] out_src_q;
    logic            out_last_q;

    logic [NREQ-1:0] rot_req;
    logic [SELW-1:0] pick_off;
    logic [SELW-1:0] pick_d;
    logic [DW-1:0]   mux_data;
    logic            can_load;
    logic            accept;

    mux4to1 u_mux (
        .d0_i  (req_data0_i),
        .d1_i  (req_data1_i),
        .d2_i  (req_data2_i),
        .d3_i  (req_data3_i),
        .sel_i (gnt_q),
        .y_o   (mux_data)
    );

    // Rotate so bit 0 is the pointer's requester, then take the lowest set bit.
    always_comb begin
        rot_req  = '0;
        pick_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot_req[k] = req_valid_i[ptr_q + SELW'(k)];
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) pick_off = SELW'(k);
        end
        pick_d = ptr_q + pick_off;
    end

    assign can_load = ~out_valid_q | out_ready_i;
    assign accept   = (state_q == ST_GRANT) & req_valid_i[gnt_q] & can_load;

    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_GRANT) req_ready_o[gnt_q] = can_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= RST_PTR;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        gnt_q   <= pick_d;
                        state_q <= ST_GRANT;
                    end
                end
                default: begin
                    if (accept && req_last_i[gnt_q]) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= gnt_q + 1'b1;
                    end
                end
            endcase

            // A load wins over a drain, so load-and-drain in one cycle has no bubble.
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_data;
                out_src_q   <= gnt_q;
                out_last_q  <= req_last_i[gnt_q];
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == ST_GRANT);
    assign gnt_o       = gnt_q;
endmodule
`default_nettype wire
